// File: rtl/mr_wb_arb_pkg.sv
// Shared types and defaults for the mr_wb_arb Wishbone arbiter slice.
package mr_pkg;

  localparam int unsigned MR_XLEN          = 32;
  localparam int unsigned MR_SELW          = MR_XLEN / 8;
  localparam int unsigned MR_ARB_MAX_OUTST = 4;

  typedef enum logic [1:0] {
    ARB_NONE,
    ARB_S0,
    ARB_S1
  } e_arb_owner;

  function automatic int unsigned outst_width(input int unsigned max_outst);
    return $clog2(max_outst + 1);
  endfunction

endpackage

// File: rtl/mr_wb_outst_ctr.sv
// Saturating up/down counter of outstanding Wishbone strobes.
// It never wraps: increments at full and decrements at empty are ignored.
module mr_wb_outst_ctr
    import mr_pkg::*;
#(
    parameter int unsigned MAX = MR_ARB_MAX_OUTST
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic dec,
    input  logic clr,
    output logic full,
    output logic empty
);
    localparam int unsigned W = outst_width(MAX);
    localparam logic [W-1:0] MAX_CNT = W'(MAX);

    logic [W-1:0] cnt_q, cnt_d;

    assign full  = (cnt_q == MAX_CNT);
    assign empty = (cnt_q == '0);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && !dec && !full) begin
            cnt_d = cnt_q + 1'b1;
        end else if (dec && !inc && !empty) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end

endmodule

// File: rtl/mr_wb_arb.sv
// Two-master (s0 ifetch, s1 LD-ST) to one-slave pipelined Wishbone arbiter, CYC-locked grants.
// Define MR_WB_ARB_LDST_PRIO_EN to make s1 win every contested grant instead of round robin.
module mr_wb_arb
    import mr_pkg::*;
#(
    parameter int unsigned MAX_OUTST = MR_ARB_MAX_OUTST
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [MR_XLEN-1:0] s0_adr_i,
    input  logic [MR_XLEN-1:0] s0_dat_i,
    output logic [MR_XLEN-1:0] s0_dat_o,
    input  logic               s0_we_i,
    input  logic [MR_SELW-1:0] s0_sel_i,
    input  logic               s0_stb_i,
    input  logic               s0_cyc_i,
    output logic               s0_ack_o,
    output logic               s0_err_o,
    output logic               s0_stall_o,
    input  logic [MR_XLEN-1:0] s1_adr_i,
    input  logic [MR_XLEN-1:0] s1_dat_i,
    output logic [MR_XLEN-1:0] s1_dat_o,
    input  logic               s1_we_i,
    input  logic [MR_SELW-1:0] s1_sel_i,
    input  logic               s1_stb_i,
    input  logic               s1_cyc_i,
    output logic               s1_ack_o,
    output logic               s1_err_o,
    output logic               s1_stall_o,
    output logic [MR_XLEN-1:0] m_adr_o,
    output logic [MR_XLEN-1:0] m_dat_o,
    output logic               m_we_o,
    output logic [MR_SELW-1:0] m_sel_o,
    output logic               m_stb_o,
    output logic               m_cyc_o,
    input  logic [MR_XLEN-1:0] m_dat_i,
    input  logic               m_ack_i,
    input  logic               m_err_i,
    input  logic               m_stall_i
);
    e_arb_owner owner_q, owner_d;
    // Master favoured on the next contested grant; reset favours s0.
    e_arb_owner rr_q, rr_d;
    logic       rel;
    logic       full, empty;
    logic       inc, dec, clr;

    always_comb begin
        owner_d = owner_q;
        rr_d    = rr_q;
        rel     = 1'b0;
        case (owner_q)
            ARB_NONE: begin
                if (s0_cyc_i && s1_cyc_i) begin
`ifdef MR_WB_ARB_LDST_PRIO_EN
                    owner_d = ARB_S1;
`else
                    owner_d = rr_q;
`endif
                end else if (s0_cyc_i) begin
                    owner_d = ARB_S0;
                end else if (s1_cyc_i) begin
                    owner_d = ARB_S1;
                end
                if (owner_d == ARB_S0)      rr_d = ARB_S1;
                else if (owner_d == ARB_S1) rr_d = ARB_S0;
            end
            ARB_S0:  rel = !s0_cyc_i;
            ARB_S1:  rel = !s1_cyc_i;
            default: rel = 1'b1;
        endcase
        if (rel) owner_d = ARB_NONE;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            owner_q <= ARB_NONE;
            rr_q    <= ARB_S0;
        end else begin
            owner_q <= owner_d;
            rr_q    <= rr_d;
        end
    end

    always_comb begin
        m_adr_o    = '0;
        m_dat_o    = '0;
        m_we_o     = 1'b0;
        m_sel_o    = '0;
        m_stb_o    = 1'b0;
        m_cyc_o    = 1'b0;
        s0_ack_o   = 1'b0;
        s0_err_o   = 1'b0;
        s0_stall_o = 1'b1;
        s1_ack_o   = 1'b0;
        s1_err_o   = 1'b0;
        s1_stall_o = 1'b1;
        case (owner_q)
            ARB_S0: begin
                m_adr_o    = s0_adr_i;
                m_dat_o    = s0_dat_i;
                m_we_o     = s0_we_i;
                m_sel_o    = s0_sel_i;
                m_stb_o    = s0_stb_i & ~full;
                m_cyc_o    = s0_cyc_i;
                s0_stall_o = m_stall_i | full;
                s0_ack_o   = m_ack_i & ~empty;
                s0_err_o   = m_err_i & ~empty;
            end
            ARB_S1: begin
                m_adr_o    = s1_adr_i;
                m_dat_o    = s1_dat_i;
                m_we_o     = s1_we_i;
                m_sel_o    = s1_sel_i;
                m_stb_o    = s1_stb_i & ~full;
                m_cyc_o    = s1_cyc_i;
                s1_stall_o = m_stall_i | full;
                s1_ack_o   = m_ack_i & ~empty;
                s1_err_o   = m_err_i & ~empty;
            end
            default: ;
        endcase
    end

    assign s0_dat_o = m_dat_i;
    assign s1_dat_o = m_dat_i;

    // Responses with nothing outstanding are stray and must not underflow the count.
    assign inc = m_stb_o & ~m_stall_i;
    assign dec = (m_ack_i | m_err_i) & ~empty;
    assign clr = rel | (owner_q == ARB_NONE);

    mr_wb_outst_ctr #(
        .MAX (MAX_OUTST)
    ) u_outst (
        .clk   (clk),
        .rst   (rst),
        .inc   (inc),
        .dec   (dec),
        .clr   (clr),
        .full  (full),
        .empty (empty)
    );

endmodule

// File: tb/tb_mr_wb_arb.sv
// Self-checking bench for mr_wb_arb: vector table, directed corner sequences and a random phase
// checked every cycle against an integer-level model of the arbitration rules.
module tb_mr_wb_arb;
    import mr_pkg::*;

    localparam int MAXO = MR_ARB_MAX_OUTST;
`ifdef MR_WB_ARB_LDST_PRIO_EN
    localparam bit PRIO = 1'b1;
`else
    localparam bit PRIO = 1'b0;
`endif
    localparam logic [MR_XLEN-1:0] S0_ADR = MR_XLEN'(32'h0000_0100);
    localparam logic [MR_XLEN-1:0] S1_ADR = MR_XLEN'(32'h0000_0200);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst;
    logic [MR_XLEN-1:0] s0_adr_i, s0_dat_i, s0_dat_o, s1_adr_i, s1_dat_i, s1_dat_o;
    logic [MR_SELW-1:0] s0_sel_i, s1_sel_i, m_sel_o;
    logic s0_we_i, s0_stb_i, s0_cyc_i, s0_ack_o, s0_err_o, s0_stall_o;
    logic s1_we_i, s1_stb_i, s1_cyc_i, s1_ack_o, s1_err_o, s1_stall_o;
    logic [MR_XLEN-1:0] m_adr_o, m_dat_o, m_dat_i;
    logic m_we_o, m_stb_o, m_cyc_o, m_ack_i, m_err_i, m_stall_i;

    mr_wb_arb #(.MAX_OUTST(MAXO)) dut (
        .clk(clk), .rst(rst),
        .s0_adr_i(s0_adr_i), .s0_dat_i(s0_dat_i), .s0_dat_o(s0_dat_o), .s0_we_i(s0_we_i),
        .s0_sel_i(s0_sel_i), .s0_stb_i(s0_stb_i), .s0_cyc_i(s0_cyc_i), .s0_ack_o(s0_ack_o),
        .s0_err_o(s0_err_o), .s0_stall_o(s0_stall_o),
        .s1_adr_i(s1_adr_i), .s1_dat_i(s1_dat_i), .s1_dat_o(s1_dat_o), .s1_we_i(s1_we_i),
        .s1_sel_i(s1_sel_i), .s1_stb_i(s1_stb_i), .s1_cyc_i(s1_cyc_i), .s1_ack_o(s1_ack_o),
        .s1_err_o(s1_err_o), .s1_stall_o(s1_stall_o),
        .m_adr_o(m_adr_o), .m_dat_o(m_dat_o), .m_we_o(m_we_o), .m_sel_o(m_sel_o),
        .m_stb_o(m_stb_o), .m_cyc_o(m_cyc_o), .m_dat_i(m_dat_i), .m_ack_i(m_ack_i),
        .m_err_i(m_err_i), .m_stall_i(m_stall_i)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference state: owner 0=none 1=s0 2=s1; pref = master winning the next contested grant.
    int mdl_owner = 0;
    int mdl_pref  = 1;
    int mdl_outst = 0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    task automatic model_check();
        logic [MR_XLEN-1:0] e_adr, e_dat;
        logic [MR_SELW-1:0] e_sel;
        logic e_we, e_cyc, e_stb, e_a0, e_a1, e_e0, e_e1, e_st0, e_st1;
        bit cap, live;
        e_adr = '0; e_dat = '0; e_sel = '0;
        e_we = 0; e_cyc = 0; e_stb = 0; e_a0 = 0; e_a1 = 0; e_e0 = 0; e_e1 = 0;
        e_st0 = 1; e_st1 = 1;
        cap  = (mdl_outst == MAXO);
        live = (mdl_outst > 0);
        if (mdl_owner == 1) begin
            e_adr = s0_adr_i; e_dat = s0_dat_i; e_sel = s0_sel_i; e_we = s0_we_i;
            e_cyc = s0_cyc_i; e_stb = s0_stb_i && !cap; e_st0 = m_stall_i || cap;
            e_a0 = m_ack_i && live; e_e0 = m_err_i && live;
        end else if (mdl_owner == 2) begin
            e_adr = s1_adr_i; e_dat = s1_dat_i; e_sel = s1_sel_i; e_we = s1_we_i;
            e_cyc = s1_cyc_i; e_stb = s1_stb_i && !cap; e_st1 = m_stall_i || cap;
            e_a1 = m_ack_i && live; e_e1 = m_err_i && live;
        end
        chk("m_cyc", m_cyc_o, e_cyc);   chk("m_stb", m_stb_o, e_stb);
        chk("m_adr", m_adr_o, e_adr);   chk("m_dat", m_dat_o, e_dat);
        chk("m_sel", m_sel_o, e_sel);   chk("m_we", m_we_o, e_we);
        chk("s0_ack", s0_ack_o, e_a0);  chk("s1_ack", s1_ack_o, e_a1);
        chk("s0_err", s0_err_o, e_e0);  chk("s1_err", s1_err_o, e_e1);
        chk("s0_stall", s0_stall_o, e_st0); chk("s1_stall", s1_stall_o, e_st1);
        chk("s0_dat_o", s0_dat_o, m_dat_i); chk("s1_dat_o", s1_dat_o, m_dat_i);
    endtask

    task automatic model_advance();
        int win, old;
        bit cyc, stb;
        old = mdl_outst;
        if (!rst) begin
            mdl_owner = 0; mdl_pref = 1; mdl_outst = 0;
        end else if (mdl_owner == 0) begin
            win = 0;
            if (s0_cyc_i && s1_cyc_i) win = PRIO ? 2 : mdl_pref;
            else if (s0_cyc_i)        win = 1;
            else if (s1_cyc_i)        win = 2;
            if (win != 0) begin
                mdl_owner = win;
                mdl_pref  = 3 - win;
            end
        end else begin
            cyc = (mdl_owner == 1) ? s0_cyc_i : s1_cyc_i;
            stb = (mdl_owner == 1) ? s0_stb_i : s1_stb_i;
            if (!cyc) begin
                mdl_owner = 0; mdl_outst = 0;
            end else begin
                if (stb && old < MAXO && !m_stall_i) mdl_outst++;
                if ((m_ack_i || m_err_i) && old > 0) mdl_outst--;
            end
        end
    endtask

    task automatic finish_cycle();
        model_check();
        model_advance();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        @(negedge clk);
        finish_cycle();
    endtask

    // Waits (bounded) for m_cyc_o; who = 1/2 for the granted master, 0 on timeout.
    task automatic wait_grant(output int who);
        who = 0;
        for (int w = 0; w < 8 && who == 0; w++) begin
            @(negedge clk);
            if (m_cyc_o) who = (m_adr_o == S1_ADR) ? 2 : 1;
            finish_cycle();
        end
    endtask

    typedef struct packed {
        logic rst, c0, t0, c1, t1, ack, err, stall;
        logic e_cyc, e_stb, e_a0, e_a1, e_st0, e_st1;
    } vec_t;
    vec_t vecs[16];

    int who, acc, nerr;

    initial begin
        rst = 0; m_dat_i = MR_XLEN'(32'hCAFE_0001); m_ack_i = 0; m_err_i = 0; m_stall_i = 0;
        s0_adr_i = S0_ADR; s0_dat_i = MR_XLEN'(32'h1111_1111); s0_we_i = 1; s0_sel_i = '1;
        s1_adr_i = S1_ADR; s1_dat_i = MR_XLEN'(32'h2222_2222); s1_we_i = 0; s1_sel_i = '1;
        s0_stb_i = 0; s0_cyc_i = 0; s1_stb_i = 0; s1_cyc_i = 0;

        //          rst c0 t0 c1 t1 ack err stl | cyc stb a0 a1 st0 st1
        vecs[0]  = 14'b0_1_0_1_0_0_0_0__0_0_0_0_1_1;
        vecs[1]  = 14'b0_1_0_1_0_0_0_0__0_0_0_0_1_1;
        vecs[2]  = 14'b0_1_0_1_0_0_0_0__0_0_0_0_1_1;
        vecs[3]  = 14'b1_1_0_1_0_0_0_0__0_0_0_0_1_1;
        vecs[4]  = 14'b1_1_1_1_0_0_0_0__1_1_0_0_0_1;
        vecs[5]  = 14'b1_1_1_1_0_0_0_0__1_1_0_0_0_1;
        vecs[6]  = 14'b1_1_1_1_0_1_0_0__1_1_1_0_0_1;
        vecs[7]  = 14'b1_1_1_1_0_1_0_0__1_1_1_0_0_1;
        vecs[8]  = 14'b1_1_0_1_0_1_0_0__1_0_1_0_0_1;
        vecs[9]  = 14'b1_1_0_1_0_1_0_0__1_0_1_0_0_1;
        vecs[10] = 14'b1_0_0_1_0_0_0_0__0_0_0_0_0_1;
        vecs[11] = 14'b1_0_0_1_0_0_0_0__0_0_0_0_1_1;
        vecs[12] = 14'b1_0_0_1_1_1_0_0__1_1_0_0_1_0;
        vecs[13] = 14'b1_0_0_1_0_1_0_0__1_0_0_1_1_0;
        vecs[14] = 14'b1_0_0_0_0_0_0_0__0_0_0_0_1_0;
        vecs[15] = 14'b1_0_0_0_0_0_0_0__0_0_0_0_1_1;

        #1;
        for (int i = 0; i < 16; i++) begin
            rst = vecs[i].rst; s0_cyc_i = vecs[i].c0; s0_stb_i = vecs[i].t0;
            s1_cyc_i = vecs[i].c1; s1_stb_i = vecs[i].t1;
            m_ack_i = vecs[i].ack; m_err_i = vecs[i].err; m_stall_i = vecs[i].stall;
            @(negedge clk);
            chk("vec_cyc", m_cyc_o, vecs[i].e_cyc);     chk("vec_stb", m_stb_o, vecs[i].e_stb);
            chk("vec_ack0", s0_ack_o, vecs[i].e_a0);    chk("vec_ack1", s1_ack_o, vecs[i].e_a1);
            chk("vec_stall0", s0_stall_o, vecs[i].e_st0); chk("vec_stall1", s1_stall_o, vecs[i].e_st1);
            finish_cycle();
        end

        // Contested grants: each owner strobes once, takes its ack, then drops cyc for one cycle.
        m_ack_i = 0; s0_cyc_i = 1; s1_cyc_i = 1;
        for (int g = 0; g < 4; g++) begin
            wait_grant(who);
            chk("grant_order", who, PRIO ? 2 : ((g % 2 == 0) ? 1 : 2));
            if (who == 2) s1_stb_i = 1; else s0_stb_i = 1;
            tick();
            s0_stb_i = 0; s1_stb_i = 0; m_ack_i = 1;
            tick();
            m_ack_i = 0;
            if (who == 2) s1_cyc_i = 0; else s0_cyc_i = 0;
            tick();
            s0_cyc_i = 1; s1_cyc_i = 1;
        end
        s0_cyc_i = 0; s1_cyc_i = 0;
        tick(); tick();

        // Outstanding cap: slave never acks, only MAXO strobes may be accepted.
        s0_cyc_i = 1; s0_stb_i = 1; acc = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (m_stb_o && !m_stall_i) acc++;
            finish_cycle();
        end
        chk("cap_accepted", acc, MAXO);
        @(negedge clk);
        chk("cap_stall", s0_stall_o, 1);
        finish_cycle();
        s0_stb_i = 0; m_ack_i = 1;
        for (int c = 0; c < MAXO; c++) tick();
        m_ack_i = 0; s0_cyc_i = 0;
        tick(); tick();

        // Abort with two strobes in flight: the late acks reach nobody.
        s0_cyc_i = 1;
        wait_grant(who);
        chk("abort_grant", who, 1);
        s0_stb_i = 1; tick(); tick();
        s0_stb_i = 0; s0_cyc_i = 0;
        tick();
        m_ack_i = 1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk("abort_cyc", m_cyc_o, 0);
            chk("abort_ack", {s0_ack_o, s1_ack_o}, 2'b00);
            finish_cycle();
        end
        m_ack_i = 0; s0_cyc_i = 1;
        wait_grant(who);
        m_ack_i = 1;
        @(negedge clk);
        chk("stray_ack", s0_ack_o, 0);
        finish_cycle();
        m_ack_i = 0; s0_cyc_i = 0;
        tick(); tick();

        // Error on the second of three strobes: forwarded once, bus stays with s1.
        s1_cyc_i = 1;
        wait_grant(who);
        chk("err_grant", who, 2);
        s1_stb_i = 1; tick(); tick(); tick();
        s1_stb_i = 0; nerr = 0;
        for (int c = 0; c < 3; c++) begin
            m_ack_i = (c != 1); m_err_i = (c == 1);
            @(negedge clk);
            if (s1_err_o) nerr++;
            finish_cycle();
        end
        m_ack_i = 0; m_err_i = 0;
        @(negedge clk);
        chk("err_pulses", nerr, 1);
        chk("err_keeps_bus", m_cyc_o, 1);
        finish_cycle();
        s1_cyc_i = 0;
        tick(); tick();

        // Random traffic against the model, with occasional resets and stray responses.
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 149) != 0);
            if ($urandom_range(0, 7) == 0) s0_cyc_i = ~s0_cyc_i;
            if ($urandom_range(0, 7) == 0) s1_cyc_i = ~s1_cyc_i;
            s0_stb_i = $urandom_range(0, 1); s1_stb_i = $urandom_range(0, 1);
            s0_we_i = $urandom_range(0, 1);  s1_we_i = $urandom_range(0, 1);
            s0_adr_i = MR_XLEN'($urandom);   s1_adr_i = MR_XLEN'($urandom);
            s0_dat_i = MR_XLEN'($urandom);   s1_dat_i = MR_XLEN'($urandom);
            s0_sel_i = MR_SELW'($urandom);   s1_sel_i = MR_SELW'($urandom);
            m_dat_i = MR_XLEN'($urandom);
            m_ack_i = ($urandom_range(0, 2) == 0);
            m_err_i = ($urandom_range(0, 9) == 0);
            m_stall_i = ($urandom_range(0, 3) == 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
